// File: rtl/pmem_line_arbiter_pkg.sv
// Shared types and default widths for the pmem line arbiter.
// This includes the cache line bus, the byte address, and the FSM/owner enums.
package pmem_line_arbiter_pkg;

  localparam int PMEM_LINE_W = 128;
  localparam int PMEM_ADDR_W = 16;
  localparam int PMEM_CNT_W  = 16;

  typedef logic [PMEM_LINE_W-1:0] mem_bus;
  typedef logic [PMEM_ADDR_W-1:0] lc3b_word;

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} arb_state_t;
  typedef enum logic {OWN_I, OWN_D} arb_owner_t;

endpackage

// File: rtl/pmem_line_arbiter_if.sv
// Downstream physical-memory line port.
// The arbiter drives it through the master modport; the memory or L2 side uses the slave modport.
interface pmem_line_arbiter_if
  import pmem_line_arbiter_pkg::*;
#(
  parameter int LINE_W = PMEM_LINE_W,
  parameter int ADDR_W = PMEM_ADDR_W
);
  logic              read;
  logic              write;
  logic [ADDR_W-1:0] addr;
  logic [LINE_W-1:0] wdata;
  logic [LINE_W-1:0] rdata;
  logic              resp;

  modport master (output read, write, addr, wdata, input rdata, resp);
  modport slave  (input read, write, addr, wdata, output rdata, resp);
endinterface

// File: rtl/pmem_line_arbiter_sat_counter.sv
// Up-counter that increments on enable and sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/pmem_line_arbiter.sv
// Arbitrates one pmem line port between the I-cache (reads) and the D-cache (reads and write-backs).
// The port serves one transaction at a time, and each transaction ends with a single-cycle response pulse.
module pmem_line_arbiter
  import pmem_line_arbiter_pkg::*;
#(
  parameter int LINE_W = PMEM_LINE_W,
  parameter int ADDR_W = PMEM_ADDR_W,
  parameter int CNT_W  = PMEM_CNT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_read,
  input  logic [ADDR_W-1:0]  i_addr,
  output logic [LINE_W-1:0]  i_rdata,
  output logic               i_resp,
  input  logic               d_read,
  input  logic               d_write,
  input  logic [ADDR_W-1:0]  d_addr,
  input  logic [LINE_W-1:0]  d_wdata,
  output logic [LINE_W-1:0]  d_rdata,
  output logic               d_resp,
  pmem_line_arbiter_if.master pmem,
  output logic [CNT_W-1:0]   perf_i_xfers,
  output logic [CNT_W-1:0]   perf_d_xfers
);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(4'hF);

  arb_state_t        state_q, state_d;
  arb_owner_t        owner_q, owner_d;
  arb_owner_t        last_q, last_d;
  logic              rd_q, rd_d, wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic [LINE_W-1:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic              d_req, grant_d;

  assign d_req   = d_read | d_write;
  // On a tie, D wins only when I was the last side granted on a tie.
  assign grant_d = d_req && (!i_read || (last_q == OWN_I));

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    case (state_q)
      IDLE: begin
        if (i_read || d_req) begin
          if (i_read && d_req) last_d = grant_d ? OWN_D : OWN_I;
          if (grant_d) begin
            owner_d = OWN_D;
            state_d = BUSY_D;
            addr_d  = d_addr & LINE_MASK;
            // A simultaneous read and write is resolved as a write.
            wr_d    = d_write;
            rd_d    = !d_write;
            if (d_write) wdata_d = d_wdata;
          end else begin
            owner_d = OWN_I;
            state_d = BUSY_I;
            addr_d  = i_addr & LINE_MASK;
            rd_d    = 1'b1;
            wr_d    = 1'b0;
          end
        end
      end
      BUSY_I: begin
        if (pmem.resp) begin
          i_rdata_d = pmem.rdata;
          rd_d      = 1'b0;
          state_d   = RESP;
        end
      end
      BUSY_D: begin
        if (pmem.resp) begin
          if (!wr_q) d_rdata_d = pmem.rdata;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      owner_q   <= OWN_I;
      last_q    <= OWN_D;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  assign pmem.read  = rd_q;
  assign pmem.write = wr_q;
  assign pmem.addr  = addr_q;
  assign pmem.wdata = wdata_q;
  assign i_rdata    = i_rdata_q;
  assign d_rdata    = d_rdata_q;
  assign i_resp     = (state_q == RESP) && (owner_q == OWN_I);
  assign d_resp     = (state_q == RESP) && (owner_q == OWN_D);

  sat_counter #(.CNT_W(CNT_W)) u_i_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (i_resp),
    .cnt_o (perf_i_xfers)
  );

  sat_counter #(.CNT_W(CNT_W)) u_d_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (d_resp),
    .cnt_o (perf_d_xfers)
  );

  a_no_rd_wr_both : assert property (@(posedge clk) disable iff (!rst_n) !(d_read && d_write));

endmodule

// File: tb/tb_pmem_line_arbiter.sv
// Directed bench for pmem_line_arbiter with a transaction scoreboard.
// A second instance with a narrow counter width shares the same stimulus.
`timescale 1ns/1ps
module tb_pmem_line_arbiter;
  import pmem_line_arbiter_pkg::*;

  localparam int SAT_W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic     i_read = 1'b0, d_read = 1'b0, d_write = 1'b0;
  lc3b_word i_addr = '0, d_addr = '0;
  mem_bus   d_wdata = '0;
  mem_bus   i_rdata, d_rdata, i_rdata_s, d_rdata_s;
  logic     i_resp, d_resp, i_resp_s, d_resp_s;
  logic [15:0]      perf_i, perf_d;
  logic [SAT_W-1:0] perf_i_s, perf_d_s;

  pmem_line_arbiter_if pm ();
  pmem_line_arbiter_if pm_s ();
  assign pm_s.rdata = pm.rdata;
  assign pm_s.resp  = pm.resp;

  pmem_line_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem(pm.master),
    .perf_i_xfers(perf_i), .perf_d_xfers(perf_d)
  );

  pmem_line_arbiter #(.CNT_W(SAT_W)) dut_s (
    .clk(clk), .rst_n(rst_n),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata_s), .i_resp(i_resp_s),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata_s), .d_resp(d_resp_s),
    .pmem(pm_s.master),
    .perf_i_xfers(perf_i_s), .perf_d_xfers(perf_d_s)
  );

  typedef struct {
    bit       own_d;
    bit       wr;
    lc3b_word addr;
    mem_bus   wdata;
    mem_bus   rdata;
  } txn_t;

  txn_t   sb[$];
  int     checks = 0;
  int     failures = 0;
  int     exp_i = 0, exp_d = 0;
  mem_bus i_shadow = '0, d_shadow = '0;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk128(input string tag, input mem_bus obs, input mem_bus exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input bit own_d, input bit wr, input lc3b_word a, input mem_bus wd, input mem_bus rd);
    txn_t t;
    t.own_d = own_d; t.wr = wr; t.addr = a & 16'hFFF0; t.wdata = wd; t.rdata = rd;
    sb.push_back(t);
    if (own_d) begin
      d_addr = a; d_wdata = wd; d_read = !wr; d_write = wr;
    end else begin
      i_addr = a; i_read = 1'b1;
    end
  endtask

  task automatic drop(input bit own_d);
    if (own_d) begin d_read = 1'b0; d_write = 1'b0; end
    else i_read = 1'b0;
  endtask

  task automatic check_counters(input string tag);
    chk16({tag, "_perf_i"}, perf_i, 16'(exp_i));
    chk16({tag, "_perf_d"}, perf_d, 16'(exp_d));
    chk16({tag, "_perf_i_sat"}, 16'(perf_i_s), 16'((exp_i > 15) ? 15 : exp_i));
    chk16({tag, "_perf_d_sat"}, 16'(perf_d_s), 16'((exp_d > 15) ? 15 : exp_d));
  endtask

  // Pops the oldest expected transaction, plays the memory side with the given latency, and checks the response.
  task automatic serve(input string tag, input int lat, input bit withdraw, output int hi);
    txn_t t;
    int   n;
    hi = 0;
    chk1({tag, "_sb_nonempty"}, sb.size() > 0, 1'b1);
    if (sb.size() == 0) return;
    t = sb.pop_front();
    n = 0;
    while (!(pm.read || pm.write) && n < 20) begin cyc(); n++; end
    chk1({tag, "_strobe_seen"}, n < 20, 1'b1);
    chk1({tag, "_pmem_read"}, pm.read, !t.wr);
    chk1({tag, "_pmem_write"}, pm.write, t.wr);
    chk16({tag, "_pmem_addr"}, pm.addr, t.addr);
    if (t.wr) chk128({tag, "_pmem_wdata"}, pm.wdata, t.wdata);
    hi = 1;
    if (withdraw) drop(t.own_d);
    for (int k = 0; k < lat; k++) begin
      cyc();
      if (pm.read || pm.write) hi++;
      chk1({tag, "_strobe_held"}, pm.read || pm.write, 1'b1);
      chk16({tag, "_addr_held"}, pm.addr, t.addr);
    end
    pm.rdata = t.rdata;
    pm.resp  = 1'b1;
    cyc();
    pm.resp  = 1'b0;
    pm.rdata = ~t.rdata;
    chk1({tag, "_strobe_dropped"}, pm.read || pm.write, 1'b0);
    chk1({tag, "_i_resp"}, i_resp, !t.own_d);
    chk1({tag, "_d_resp"}, d_resp, t.own_d);
    if (!t.own_d) begin i_shadow = t.rdata; exp_i++; end
    else begin
      if (!t.wr) d_shadow = t.rdata;
      exp_d++;
    end
    chk128({tag, "_i_rdata"}, i_rdata, i_shadow);
    chk128({tag, "_d_rdata"}, d_rdata, d_shadow);
    drop(t.own_d);
    cyc();
    chk1({tag, "_resp_one_cycle"}, i_resp || d_resp, 1'b0);
    check_counters(tag);
  endtask

  initial begin
    int hi;
    int n;
    pm.resp  = 1'b0;
    pm.rdata = '0;

    cyc(); cyc();
    chk1("rst_pmem_read", pm.read, 1'b0);
    chk1("rst_pmem_write", pm.write, 1'b0);
    chk16("rst_pmem_addr", pm.addr, 16'h0);
    chk1("rst_i_resp", i_resp, 1'b0);
    chk1("rst_d_resp", d_resp, 1'b0);
    check_counters("rst");
    rst_n = 1'b1;
    cyc();

    // Single I read with 3-cycle memory latency.
    req(1'b0, 1'b0, 16'h1236, '0, {16{8'hA5}});
    serve("iread", 3, 1'b0, hi);
    chk16("iread_strobe_cycles", 16'(hi), 16'd4);

    // Tie with last tie-winner still D from reset: I first, then D write.
    req(1'b0, 1'b0, 16'h2004, '0, {4{32'h1111_2222}});
    req(1'b1, 1'b1, 16'h300C, {4{32'hDEAD_BEEF}}, {4{32'h0BAD_0BAD}});
    serve("tie1_i", 1, 1'b0, hi);
    serve("tie1_d", 2, 1'b0, hi);

    // Second tie flips priority: D read first, then I.
    req(1'b1, 1'b0, 16'h5000, '0, {4{32'h5555_AAAA}});
    req(1'b0, 1'b0, 16'h4008, '0, {4{32'h3C3C_C3C3}});
    serve("tie2_d", 0, 1'b0, hi);
    serve("tie2_i", 1, 1'b0, hi);

    // D write to the top line; d_rdata must keep the last read value.
    req(1'b1, 1'b1, 16'hFFFF, {4{32'h0123_CDEF}}, {4{32'hFEED_FACE}});
    serve("dwrite", 2, 1'b0, hi);

    // D read withdrawn right after grant still completes.
    req(1'b1, 1'b0, 16'h0100, '0, {4{32'h7777_0001}});
    serve("withdraw", 4, 1'b1, hi);
    chk16("withdraw_strobe_cycles", 16'(hi), 16'd5);

    // Stray memory response while idle is ignored.
    pm.resp = 1'b1;
    cyc();
    pm.resp = 1'b0;
    chk1("stray_no_strobe", pm.read || pm.write, 1'b0);
    chk1("stray_no_resp", i_resp || d_resp, 1'b0);
    cyc();
    chk1("stray_no_resp_late", i_resp || d_resp, 1'b0);
    check_counters("stray");

    // Reset in the middle of a D write.
    req(1'b1, 1'b1, 16'h7777, {4{32'h9999_8888}}, '0);
    n = 0;
    while (!pm.write && n < 20) begin cyc(); n++; end
    chk1("midrst_write_seen", pm.write, 1'b1);
    sb.delete();
    #2 rst_n = 1'b0;
    #1;
    chk1("midrst_write_drop", pm.write, 1'b0);
    chk1("midrst_read_low", pm.read, 1'b0);
    chk1("midrst_d_resp", d_resp, 1'b0);
    exp_i = 0; exp_d = 0; i_shadow = '0; d_shadow = '0;
    check_counters("midrst");
    chk128("midrst_i_rdata", i_rdata, '0);
    d_write = 1'b0;
    cyc(); cyc();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk1("postrst_no_d_resp", d_resp, 1'b0);
      chk1("postrst_no_write", pm.write, 1'b0);
    end

    // Drive past the narrow counter limit; the wide one keeps counting.
    for (int k = 0; k < 17; k++) begin
      req(1'b0, 1'b0, 16'(k * 16 + 3), '0, {4{32'(k) ^ 32'hC0DE_0000}});
      serve("sat", 0, 1'b0, hi);
    end
    chk16("sat_hold", 16'(perf_i_s), 16'hF);
    chk16("sat_wide", perf_i, 16'd17);
    chk16("sat_d_unaffected", 16'(perf_d_s), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
